bus_dev_port: RTL and testbench

Device-side endpoint for the shared bus generator/arbiter. It is the RTL counterpart of the per-device FIFO model that currently drives the bus's `pndng`/`pop`/`D_pop` and `push`/`D_push` lines in simulation. It buffers packets a local device wants to send (the TX path, which the bus pops) and packets the bus delivers to this device (the RX path, which the bus pushes and the device reads). One instance sits at each of the bus's `drvrs` device slots.

---
 rtl/bus_dev_pkg.sv | 28 ++
 rtl/bus_dev_fifo.sv | 44 ++++
 rtl/bus_dev_port.sv | 103 ++++++++++
 tb/tb_bus_dev_port.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dev_pkg.sv
// Shared types and helpers for the bus device endpoint: IDs, error flags and
// destination extraction from a packet.
package bus_dev_pkg;

  localparam int unsigned ID_W      = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;
  localparam int unsigned PKT_MAX_W = 64;

  typedef struct packed {
    logic tx_ovf;
    logic bus_err;
    logic rx_ovf;
  } err_flags_t;

  // Destination ID is the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [PKT_MAX_W-1:0] pkt,
                                              input int unsigned pkt_w);
    logic [PKT_MAX_W-1:0] sh;
    sh = pkt >> (pkt_w - ID_W);
    return sh[ID_W-1:0];
  endfunction

  function automatic logic addressed_to(input logic [ID_W-1:0] dest,
                                        input logic [ID_W-1:0] dev_id);
    return (dest == dev_id) || (dest == BCAST_ID);
  endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// Show-ahead synchronous FIFO. Callers must only assert wr when there is room
// (or rd is asserted together) and rd when non-empty.
module bus_dev_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [W-1:0] din,
  input  logic         rd,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Write while full with a same-cycle read lands in the slot being read out.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_comb begin
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/bus_dev_port.sv
// Device-side bus endpoint: TX FIFO popped by the bus, RX FIFO pushed by the
// bus with destination filtering, sticky error flags and a drop counter.
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int unsigned     PCKG_SZ = 24,
  parameter int unsigned     DEPTH   = 8,
  parameter logic [ID_W-1:0] DEV_ID  = 8'd0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  input  logic               pop,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  input  logic               tx_wr,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic               rx_vld,
  input  logic               clr_err,
  output logic               tx_ovf,
  output logic               bus_err,
  output logic               rx_ovf,
  output logic [7:0]         drop_cnt
);

  logic       tx_empty;
  logic       rx_full;
  logic       rx_empty;

  logic       tx_push;
  logic       tx_pop;
  logic       rx_push;
  logic       rx_pop;
  logic       dest_ok;
  logic       drop_evt;
  err_flags_t err_evt;
  err_flags_t err_q;

  bus_dev_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .wr    (tx_push),
    .din   (tx_data),
    .rd    (tx_pop),
    .dout  (D_pop),
    .full  (tx_full),
    .empty (tx_empty)
  );

  bus_dev_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (reset),
    .wr    (rx_push),
    .din   (D_push),
    .rd    (rx_pop),
    .dout  (rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    tx_pop  = pop & ~tx_empty;
    // A pop while full frees the slot for the same-cycle write.
    tx_push = tx_wr & (~tx_full | tx_pop);

    dest_ok = addressed_to(dest_of(PKT_MAX_W'(D_push), PCKG_SZ), DEV_ID);
    rx_pop  = rx_rd & ~rx_empty;
    rx_push = push & dest_ok & (~rx_full | rx_pop);

    err_evt         = '0;
    err_evt.tx_ovf  = tx_wr & ~tx_push;
    err_evt.bus_err = pop & tx_empty;
    err_evt.rx_ovf  = push & dest_ok & ~rx_push;
    drop_evt        = push & ~rx_push;
  end

  // Same-cycle events take precedence over clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q    <= '0;
      drop_cnt <= '0;
    end else begin
      err_q <= (clr_err ? err_flags_t'('0) : err_q) | err_evt;
      if (clr_err)
        drop_cnt <= drop_evt ? 8'd1 : 8'd0;
      else if (drop_evt && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_comb begin
    pndng   = ~tx_empty;
    rx_vld  = ~rx_empty;
    tx_ovf  = err_q.tx_ovf;
    bus_err = err_q.bus_err;
    rx_ovf  = err_q.rx_ovf;
  end

endmodule

// File: tb/tb_bus_dev_port.sv
// Randomised scoreboard bench for bus_dev_port (DEV_ID=3, DEPTH=8, 24-bit packets).
module tb_bus_dev_port;

  localparam int DEPTH = 8;
  localparam int MYID  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic        pop;
  logic [23:0] D_pop;
  logic        push;
  logic [23:0] D_push;
  logic        tx_wr;
  logic [23:0] tx_data;
  logic        tx_full;
  logic        rx_rd;
  logic [23:0] rx_data;
  logic        rx_vld;
  logic        clr_err;
  logic        tx_ovf;
  logic        bus_err;
  logic        rx_ovf;
  logic [7:0]  drop_cnt;

  bus_dev_port #(.PCKG_SZ(24), .DEPTH(DEPTH), .DEV_ID(8'd3)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop), .D_pop(D_pop),
    .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_vld(rx_vld),
    .clr_err(clr_err), .tx_ovf(tx_ovf), .bus_err(bus_err), .rx_ovf(rx_ovf),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: occupancies, sticky flags, drop count, expected data queues.
  logic [23:0] exp_tx[$];
  logic [23:0] exp_rx[$];
  int m_tx_n = 0;
  int m_rx_n = 0;
  bit m_tx_ovf = 0;
  bit m_bus_err = 0;
  bit m_rx_ovf = 0;
  int m_drop = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT hands out a packet, compare it with the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (pop && pndng) begin
        if (exp_tx.size() == 0) chk("tx_unexpected_pop", 1, 0);
        else chk("tx_data", D_pop, exp_tx.pop_front());
      end
      if (rx_rd && rx_vld) begin
        if (exp_rx.size() == 0) chk("rx_unexpected_read", 1, 0);
        else chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  task automatic check_status();
    chk("pndng",    pndng,    m_tx_n > 0);
    chk("tx_full",  tx_full,  m_tx_n == DEPTH);
    chk("rx_vld",   rx_vld,   m_rx_n > 0);
    chk("tx_ovf",   tx_ovf,   m_tx_ovf);
    chk("bus_err",  bus_err,  m_bus_err);
    chk("rx_ovf",   rx_ovf,   m_rx_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (m_tx_n == 0) chk("D_pop_empty", D_pop, 0);
    if (m_rx_n == 0) chk("rx_data_empty", rx_data, 0);
  endtask

  // Drive one cycle of inputs (called at posedge+1), predict, then check after the edge.
  task automatic step(input bit wr, input logic [23:0] wd, input bit p,
                      input bit ps, input logic [23:0] pd, input bit rd, input bit clr);
    bit pop_ok, wr_ok, rd_ok, match, acc, drop;
    int dest;
    tx_wr = wr; tx_data = wd; pop = p; push = ps; D_push = pd; rx_rd = rd; clr_err = clr;
    pop_ok = p && (m_tx_n > 0);
    wr_ok  = wr && ((m_tx_n < DEPTH) || pop_ok);
    dest   = int'(pd) / 65536;
    match  = (dest == MYID) || (dest == 255);
    rd_ok  = rd && (m_rx_n > 0);
    acc    = ps && match && ((m_rx_n < DEPTH) || rd_ok);
    drop   = ps && !acc;
    if (wr_ok) exp_tx.push_back(wd);
    if (acc) exp_rx.push_back(pd);
    @(posedge clk);
    #1;
    if (clr) begin
      m_tx_ovf = 0; m_bus_err = 0; m_rx_ovf = 0; m_drop = 0;
    end
    if (wr && !wr_ok) m_tx_ovf = 1;
    if (p && m_tx_n == 0) m_bus_err = 1;
    if (ps && match && !acc) m_rx_ovf = 1;
    if (drop && m_drop < 255) m_drop++;
    m_tx_n += int'(wr_ok) - int'(pop_ok);
    m_rx_n += int'(acc) - int'(rd_ok);
    check_status();
  endtask

  task automatic idle();
    step(0, 24'h0, 0, 0, 24'h0, 0, 0);
  endtask

  task automatic model_reset();
    exp_tx.delete(); exp_rx.delete();
    m_tx_n = 0; m_rx_n = 0; m_drop = 0;
    m_tx_ovf = 0; m_bus_err = 0; m_rx_ovf = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] d;
    reset = 1'b0;
    tx_wr = 0; tx_data = '0; pop = 0; push = 0; D_push = '0; rx_rd = 0; clr_err = 0;
    repeat (2) @(posedge clk);
    #1;
    check_status();
    reset = 1'b1;
    idle();

    // TX ordering
    step(1, 24'h050001, 0, 0, 0, 0, 0);
    chk("pndng_after_first_wr", pndng, 1);
    step(1, 24'h050002, 0, 0, 0, 0, 0);
    step(1, 24'h050003, 0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    chk("pndng_drained", pndng, 0);

    // TX full, overflow, pop+write at full, drain
    for (int i = 0; i < 9; i++) step(1, 24'h0A0000 + 24'(i), 0, 0, 0, 0, 0);
    chk("tx_full_after_9", tx_full, 1);
    chk("tx_ovf_after_9", tx_ovf, 1);
    step(1, 24'h0A00FF, 1, 0, 0, 0, 0);
    chk("tx_full_after_popwr", tx_full, 1);
    repeat (DEPTH) step(0, 0, 1, 0, 0, 0, 0);

    // Underflow and clear; write+pop while empty
    step(0, 0, 1, 0, 0, 0, 0);
    chk("bus_err_underflow", bus_err, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("bus_err_cleared", bus_err, 0);
    step(1, 24'h0B0001, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1);

    // RX filter
    step(0, 0, 0, 1, 24'h03AAAA, 0, 0);
    step(0, 0, 0, 1, 24'hFFBBBB, 0, 0);
    step(0, 0, 0, 1, 24'h07CCCC, 0, 0);
    chk("drop_cnt_filter", drop_cnt, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1, 1);

    // RX overflow, push+read at full, saturation, clear-vs-event
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 24'h030000 + 24'(i), 0, 0);
    chk("rx_ovf_set", rx_ovf, 1);
    chk("drop_cnt_ovf", drop_cnt, 1);
    step(0, 0, 0, 1, 24'hFF0100, 1, 0);
    chk("drop_cnt_push_rd_full", drop_cnt, 1);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 24'h100000 + 24'(i), 0, 0);
    chk("drop_cnt_saturated", drop_cnt, 255);
    step(0, 0, 0, 1, 24'h200000, 0, 1);
    chk("drop_cnt_clr_with_event", drop_cnt, 1);
    repeat (DEPTH) step(0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic: fill-biased then drain-biased
    for (int i = 0; i < 600; i++) begin
      int sel;
      bit fill;
      fill = (i % 200) < 100;
      sel = $urandom_range(0, 3);
      d = 24'($urandom);
      if (sel == 0) d[23:16] = 8'd3;
      else if (sel == 1) d[23:16] = 8'hFF;
      step(($urandom % 4) < (fill ? 3 : 1), 24'($urandom),
           ($urandom % 4) < (fill ? 1 : 3),
           ($urandom % 4) < (fill ? 3 : 1), d,
           ($urandom % 4) < (fill ? 1 : 3),
           ($urandom % 50) == 0);
    end

    // Async reset with both FIFOs partly filled and errors pending
    repeat (DEPTH) step(0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 24'h0C0000 + 24'(i), 0, 1, 24'h030000 + 24'(i), 0, 0);
    step(0, 0, 0, 1, 24'h550000, 0, 0);
    tx_wr = 0; pop = 0; push = 0; rx_rd = 0; clr_err = 0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_pndng", pndng, 0);
    chk("rst_rx_vld", rx_vld, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_D_pop", D_pop, 0);
    chk("rst_rx_data", rx_data, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    step(1, 24'h0D0001, 0, 1, 24'hFF0002, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
